// File: rtl/riscv_fetch_pkg.sv
// Shared widths, constants and FSM state encoding for the PC / instruction-fetch front end.
package riscv_fetch_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned PC_STEP = 4;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

   typedef logic [1:0] fetch_state_t;

   localparam fetch_state_t FETCH = 2'd0;
   localparam fetch_state_t WAIT  = 2'd1;
   localparam fetch_state_t HOLD  = 2'd2;
   localparam fetch_state_t DROP  = 2'd3;

endpackage

// File: rtl/pc_fetch_unit_buffer.sv
// Single-entry {instr, pc} holding register between instruction memory and decode.
module fetch_buffer
   import riscv_fetch_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               push,
   input  logic               pop,
   input  logic               flush,
   input  logic [INSTR_W-1:0] push_instr,
   input  logic [ADDR_W-1:0]  push_pc,
   output logic               buf_valid,
   output logic [INSTR_W-1:0] buf_instr,
   output logic [ADDR_W-1:0]  buf_pc
);

   // Flush wins over push so a redirect never lets a stale word through.
   always_ff @(posedge clock) begin
      if (!reset) begin
         buf_valid <= 1'b0;
         buf_instr <= '0;
         buf_pc    <= '0;
      end else if (flush) begin
         buf_valid <= 1'b0;
      end else if (push) begin
         buf_valid <= 1'b1;
         buf_instr <= push_instr;
         buf_pc    <= push_pc;
      end else if (pop) begin
         buf_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction-fetch sequencer.
// Optional misaligned-redirect trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_fetch_unit
   import riscv_fetch_pkg::*;
#(
   parameter int unsigned       ADDR_W       = 32,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(32'h0000_0000)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_target,
   output logic [ADDR_W-1:0]  pc_o,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [ADDR_W-1:0]  imem_req_addr,
   input  logic               imem_resp_valid,
   input  logic [INSTR_W-1:0] imem_resp_data,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr_data,
   output logic [ADDR_W-1:0]  instr_pc
`ifdef PC_MISALIGN_TRAP_EN
   ,
   output logic               misalign_o,
   output logic [ADDR_W-1:0]  misalign_addr
`endif
);

   fetch_state_t      state, state_nxt;
   logic [ADDR_W-1:0] pc, pc_nxt;
   logic [ADDR_W-1:0] req_pc, req_pc_nxt;
   logic              redir_c;
   logic [ADDR_W-1:0] target_c;
   logic              push, pop, flush;
   logic              buf_valid;

`ifdef PC_MISALIGN_TRAP_EN
   logic reject_c;

   // A rejected redirect behaves as if no redirect were presented.
   assign reject_c = redirect_valid && (redirect_target[1:0] != 2'b00);
   assign redir_c  = redirect_valid && !reject_c;
   assign target_c = redirect_target;

   always_ff @(posedge clock) begin
      if (!reset) begin
         misalign_o    <= 1'b0;
         misalign_addr <= '0;
      end else begin
         misalign_o <= reject_c;
         if (reject_c) misalign_addr <= redirect_target;
      end
   end
`else
   assign redir_c  = redirect_valid;
   assign target_c = redirect_target & ~ADDR_W'(3);
`endif

   assign pc_o           = pc;
   assign imem_req_valid = (state == FETCH) && !redir_c;
   assign imem_req_addr  = pc;
   assign instr_valid    = buf_valid && !redir_c;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state  <= FETCH;
         pc     <= RESET_VECTOR;
         req_pc <= '0;
      end else begin
         state  <= state_nxt;
         pc     <= pc_nxt;
         req_pc <= req_pc_nxt;
      end
   end

   // Redirect overrides every normal transition; DROP always leaves on the discarded response.
   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc;
      req_pc_nxt = req_pc;
      push       = 1'b0;
      pop        = 1'b0;
      flush      = 1'b0;
      if (redir_c) pc_nxt = target_c;
      case (state)
         FETCH: begin
            if (!redir_c && imem_req_ready) begin
               req_pc_nxt = pc;
               pc_nxt     = pc + ADDR_W'(PC_STEP);
               state_nxt  = WAIT;
            end
         end
         WAIT: begin
            if (redir_c) begin
               state_nxt = imem_resp_valid ? FETCH : DROP;
            end else if (imem_resp_valid) begin
               push      = 1'b1;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (redir_c) begin
               flush     = 1'b1;
               state_nxt = FETCH;
            end else if (instr_valid && instr_ready) begin
               pop       = 1'b1;
               state_nxt = FETCH;
            end
         end
         DROP: begin
            if (imem_resp_valid) state_nxt = FETCH;
         end
         default: state_nxt = FETCH;
      endcase
   end

   fetch_buffer #(
      .ADDR_W (ADDR_W)
   ) u_buffer (
      .clock      (clock),
      .reset      (reset),
      .push       (push),
      .pop        (pop),
      .flush      (flush),
      .push_instr (imem_resp_data),
      .push_pc    (req_pc),
      .buf_valid  (buf_valid),
      .buf_instr  (instr_data),
      .buf_pc     (instr_pc)
   );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed + random bench for pc_fetch_unit against a transaction-level fetch model.
module tb_pc_fetch_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [31:0] pc_o;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;
`ifdef PC_MISALIGN_TRAP_EN
   logic        misalign_o;
   logic [31:0] misalign_addr;
`endif

   always #5 clock = ~clock;

   pc_fetch_unit dut (
      .clock           (clock),
      .reset           (reset),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .pc_o            (pc_o),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .instr_data      (instr_data),
      .instr_pc        (instr_pc)
`ifdef PC_MISALIGN_TRAP_EN
      ,
      .misalign_o      (misalign_o),
      .misalign_addr   (misalign_addr)
`endif
   );

   int n_cmp = 0;
   int n_err = 0;

   // reference model: architectural PC plus what is outstanding / buffered
   bit          m_known = 0;
   bit          m_waiting = 0, m_dropping = 0, m_buf_valid = 0, m_show_data = 0;
   logic [31:0] m_pc = 0, m_req_pc = 0, m_buf_instr = 0, m_buf_pc = 0;

   // memory environment
   bit          mem_pending = 0;
   int          mem_cnt = 0;
   int          mem_lat = 1;
   logic [31:0] mem_addr = 0;

   // drive requests for the next cycle
   bit          d_reset_n = 0, d_redir = 0, d_ready_en = 1, d_instr_ready = 1;
   logic [31:0] d_target = 0;

   // observation logs
   logic [31:0] req_log[$];
   int          req_cyc[$];
   logic [31:0] dec_log[$];
   int          iv_seen = 0;
   int          cyc = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'd2654435761) ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      bit          resp, redir, exp_rv, exp_iv, accept;
      logic [31:0] word, pc_before;
      resp = mem_pending && (mem_cnt == 1);
      word = mem_word(mem_addr);
`ifdef PC_MISALIGN_TRAP_EN
      redir = d_redir && (d_target[1:0] == 2'b00);
`else
      redir = d_redir;
`endif
      reset           = d_reset_n;
      redirect_valid  = d_redir;
      redirect_target = d_target;
      imem_req_ready  = d_ready_en && !mem_pending;
      imem_resp_valid = resp;
      imem_resp_data  = resp ? word : $urandom;
      instr_ready     = d_instr_ready;
      #1;
      exp_rv = !m_waiting && !m_dropping && !m_buf_valid && !redir;
      exp_iv = m_buf_valid && !redir;
      if (m_known) begin
         chk("pc_o", pc_o, m_pc);
         chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
         if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
         chk("instr_valid", 32'(instr_valid), 32'(exp_iv));
         if (m_buf_valid || m_show_data) begin
            chk("instr_data", instr_data, m_buf_instr);
            chk("instr_pc", instr_pc, m_buf_pc);
         end
      end
      if (d_reset_n && imem_req_valid && imem_req_ready) begin
         req_log.push_back(imem_req_addr);
         req_cyc.push_back(cyc);
      end
      if (instr_valid) iv_seen++;
      if (instr_valid && instr_ready) dec_log.push_back(instr_pc);
      @(posedge clock);
      accept    = d_reset_n && exp_rv && d_ready_en && !mem_pending;
      pc_before = m_pc;
      if (!d_reset_n) begin
         m_known = 1; m_pc = 32'h0; m_waiting = 0; m_dropping = 0;
         m_buf_valid = 0; m_buf_instr = 0; m_buf_pc = 0; m_show_data = 1;
      end else if (redir) begin
         m_pc = d_target & 32'hFFFF_FFFC;
         if (m_waiting) begin
            m_waiting  = 0;
            m_dropping = !resp;
         end else if (m_dropping && resp) begin
            m_dropping = 0;
         end
         m_buf_valid = 0;
      end else if (accept) begin
         m_req_pc  = m_pc;
         m_pc      = m_pc + 32'd4;
         m_waiting = 1;
      end else if (m_waiting && resp) begin
         m_buf_instr = word; m_buf_pc = m_req_pc; m_buf_valid = 1;
         m_waiting = 0; m_show_data = 0;
      end else if (m_buf_valid && d_instr_ready) begin
         m_buf_valid = 0;
      end else if (m_dropping && resp) begin
         m_dropping = 0;
      end
      if (resp) mem_pending = 0;
      else if (mem_pending) mem_cnt--;
      if (accept) begin
         mem_pending = 1; mem_cnt = mem_lat; mem_addr = pc_before;
      end
      cyc++;
      @(negedge clock);
   endtask

   task automatic wait_buf(input int max_c);
      int n = 0;
      while (!m_buf_valid && n < max_c) begin tick(); n++; end
      chk("wait_buffer_timeout", 32'(m_buf_valid), 32'd1);
   endtask

   task automatic wait_waiting(input int max_c);
      int n = 0;
      while (!m_waiting && n < max_c) begin tick(); n++; end
      chk("wait_request_timeout", 32'(m_waiting), 32'd1);
   endtask

   initial begin
      logic [31:0] exp_addr [3];
      logic [31:0] pc_hold;
      exp_addr[0] = 32'h0; exp_addr[1] = 32'h4; exp_addr[2] = 32'h8;
      @(negedge clock);

      // back-to-back fetch after reset, zero-wait memory
      d_reset_n = 0; d_ready_en = 1; d_instr_ready = 1; mem_lat = 1;
      tick(); tick();
      d_reset_n = 1;
      req_log.delete(); req_cyc.delete(); dec_log.delete(); cyc = 0;
      repeat (9) tick();
      chk("t1_req_count", 32'(req_log.size()), 32'd3);
      chk("t1_dec_count", 32'(dec_log.size()), 32'd3);
      for (int i = 0; i < 3; i++) begin
         if (i < req_log.size()) begin
            chk("t1_req_addr", req_log[i], exp_addr[i]);
            chk("t1_req_cycle", 32'(req_cyc[i]), 32'(3 * i));
         end
         if (i < dec_log.size()) chk("t1_instr_pc", dec_log[i], exp_addr[i]);
      end

      // decode stall in HOLD
      d_instr_ready = 0;
      wait_buf(10);
      req_log.delete();
      repeat (5) tick();
      chk("t2_no_req_in_stall", 32'(req_log.size()), 32'd0);
      d_instr_ready = 1;
      tick(); tick();
      chk("t2_resume_req", 32'(req_log.size()), 32'd1);

      // redirect while WAIT, response arrives later and is dropped
      mem_lat = 3;
      wait_buf(20);
      wait_waiting(20);
      d_redir = 1; d_target = 32'h100;
      tick();
      d_redir = 0; iv_seen = 0; req_log.delete();
      repeat (6) tick();
      chk("t3_req_seen", 32'(req_log.size() >= 1), 32'd1);
      if (req_log.size() >= 1) chk("t3_req_addr", req_log[0], 32'h100);
      chk("t3_no_stale_instr", 32'(iv_seen), 32'd0);

      // redirect in HOLD with decode ready
      mem_lat = 1;
      wait_buf(20);
      d_redir = 1; d_target = 32'h200; d_instr_ready = 1; dec_log.delete();
      tick();
      chk("t4_no_handshake", 32'(dec_log.size()), 32'd0);
      d_redir = 0; req_log.delete();
      tick(); tick();
      chk("t4_req_seen", 32'(req_log.size() >= 1), 32'd1);
      if (req_log.size() >= 1) chk("t4_req_addr", req_log[0], 32'h200);

      // reset during WAIT
      mem_lat = 3;
      wait_buf(20);
      wait_waiting(20);
      d_reset_n = 0;
      tick();
      d_reset_n = 1;
      chk("t5_pc_after_reset", pc_o, 32'h0);
      chk("t5_iv_after_reset", 32'(instr_valid), 32'd0);
      chk("t5_data_after_reset", instr_data, 32'h0);
      mem_lat = 1;
      repeat (4) tick();

      // sequential wrap from the top of the address space
      d_redir = 1; d_target = 32'hFFFF_FFFC;
      tick();
      d_redir = 0; req_log.delete();
      repeat (10) tick();
      chk("t6_two_reqs", 32'(req_log.size() >= 2), 32'd1);
      if (req_log.size() >= 2) begin
         chk("t6_req_top", req_log[0], 32'hFFFF_FFFC);
         chk("t6_req_wrap", req_log[1], 32'h0);
      end

      // misaligned redirect target
      repeat (3) tick();
      pc_hold = m_pc;
      d_redir = 1; d_target = 32'h102;
      tick();
      d_redir = 0;
`ifdef PC_MISALIGN_TRAP_EN
      chk("t7_misalign_pulse", 32'(misalign_o), 32'd1);
      chk("t7_misalign_addr", misalign_addr, 32'h102);
      chk("t7_pc_kept", pc_o, pc_hold);
      tick();
      chk("t7_misalign_clear", 32'(misalign_o), 32'd0);
`else
      chk("t7_pc_aligned", pc_o, 32'h100);
      req_log.delete();
      repeat (6) tick();
      chk("t7_req_seen", 32'(req_log.size() >= 1), 32'd1);
      if (req_log.size() >= 1) chk("t7_req_addr", req_log[0], 32'h100);
`endif

      // random traffic against the model
      for (int i = 0; i < 600; i++) begin
         d_reset_n     = ($urandom_range(63) != 0);
         d_redir       = ($urandom_range(7) == 0);
         d_target      = $urandom;
         d_ready_en    = ($urandom_range(3) != 0);
         d_instr_ready = $urandom_range(1) != 0;
         mem_lat       = int'($urandom_range(3, 1));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
